// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the mult/div issue controller
package multdiv_pkg;

  // Controller state: accept in IDLE, one-cycle start pulse in ISSUE,
  // wait for the unit in BUSY, hold the writeback payload in DONE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  // Exception writeback goes to $rstatus with an op-specific code.
  localparam int unsigned RSTATUS_REG = 30;
  localparam int unsigned EXC_MUL     = 4;
  localparam int unsigned EXC_DIV     = 5;

endpackage

// File: rtl/multdiv_watchdog.sv
// rtl/multdiv_watchdog.sv - BUSY-cycle watchdog for the mult/div issue controller
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero the counter (held while the controller is in ISSUE)
//   count_en     : count one cycle (controller is in BUSY)
//   expired      : high in the BUSY cycle that completes TIMEOUT_CYCLES cycles
module multdiv_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

  // The count value during BUSY cycle k (first BUSY cycle is k=0) is k, so the
  // flag fires on the last of TIMEOUT_CYCLES BUSY cycles and the controller
  // leaves BUSY on the next edge.
  assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/writeback controller in front of the mult/div unit
// Optional watchdog: define MULTDIV_TIMEOUT_EN to time out BUSY after TIMEOUT_CYCLES.
// Ports:
//   clock, reset                         : clock, synchronous active-high reset
//   req_valid, req_is_mult, req_is_div   : request from execute (mult wins if both)
//   req_a, req_b, req_rd                 : operands and destination register
//   flush                                : kill any accepted or in-flight operation
//   stall                                : registered freeze of stages up to execute
//   ctrl_MULT, ctrl_DIV                  : one-cycle start pulses to the unit
//   data_operandA, data_operandB         : registered operands, held until next accept
//   data_result, data_exception,
//   data_resultRDY                       : completion from the unit
//   wb_valid, wb_ready, wb_rd, wb_data   : writeback handshake and payload
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_is_mult,
  input  logic              req_is_div,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [REG_W-1:0]  req_rd,
  input  logic              flush,
  output logic              stall,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_operandA,
  output logic [DATA_W-1:0] data_operandB,
  input  logic [DATA_W-1:0] data_result,
  input  logic              data_exception,
  input  logic              data_resultRDY,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  md_state_t        state;
  md_state_t        state_next;
  logic             op_mult_q;
  logic [REG_W-1:0] rd_q;
  logic             accept;
  logic             wd_expired;
  logic             capture;
  logic             capture_exc;

  assign accept = req_valid && (req_is_mult || req_is_div) && !flush;

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == ST_ISSUE),
    .count_en (state == ST_BUSY),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    ctrl_MULT   = 1'b0;
    ctrl_DIV    = 1'b0;
    wb_valid    = 1'b0;
    capture     = 1'b0;
    capture_exc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        // RDY is deliberately not looked at here: any RDY now belongs to a
        // killed operation. The pulse is driven even if flush is high.
        ctrl_MULT  = op_mult_q;
        ctrl_DIV   = !op_mult_q;
        state_next = flush ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (data_resultRDY) begin
          capture     = 1'b1;
          capture_exc = data_exception;
          state_next  = ST_DONE;
        end else if (wd_expired) begin
          capture     = 1'b1;
          capture_exc = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Hiding valid under flush keeps a killed result from handshaking.
        wb_valid = !flush;
        if (flush || wb_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      stall         <= 1'b0;
      op_mult_q     <= 1'b0;
      rd_q          <= '0;
      data_operandA <= '0;
      data_operandB <= '0;
      wb_rd         <= '0;
      wb_data       <= '0;
    end else begin
      state <= state_next;
      // Registered stall mirrors "not idle" of the upcoming cycle, so it drops
      // the cycle after the handshake or flush.
      stall <= (state_next != ST_IDLE);
      if (state == ST_IDLE && accept) begin
        op_mult_q     <= req_is_mult;
        rd_q          <= req_rd;
        data_operandA <= req_a;
        data_operandB <= req_b;
      end
      if (capture) begin
        if (capture_exc) begin
          wb_rd   <= REG_W'(RSTATUS_REG);
          wb_data <= op_mult_q ? DATA_W'(EXC_MUL) : DATA_W'(EXC_DIV);
        end else begin
          wb_rd   <= rd_q;
          wb_data <= data_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - directed scoreboard bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid, req_is_mult, req_is_div;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  multdiv_issue_ctrl #(
    .DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_is_mult(req_is_mult), .req_is_div(req_is_div),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .stall(stall), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Unit model: latency m_lat after the start pulse, exception on div by zero,
  // m_hang suppresses RDY. inj_* overrides the bus to fake a stale RDY.
  int          m_lat  = 17;
  bit          m_hang = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_rdy  = 1'b0;
  logic        m_exc  = 1'b0;
  logic [31:0] m_res  = '0;
  int          m_cnt  = 0;
  logic        inj_rdy  = 1'b0;
  logic [31:0] inj_data = '0;

  assign data_resultRDY = m_rdy | inj_rdy;
  assign data_result    = inj_rdy ? inj_data : m_res;
  assign data_exception = inj_rdy ? 1'b0 : m_exc;

  always @(posedge clock) begin
    m_rdy <= 1'b0;
    if (ctrl_MULT || ctrl_DIV) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
      if (ctrl_MULT) begin
        m_res <= data_operandA * data_operandB;
        m_exc <= 1'b0;
      end else if (data_operandB == '0) begin
        m_res <= '0;
        m_exc <= 1'b1;
      end else begin
        m_res <= data_operandA / data_operandB;
        m_exc <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_rdy  <= !m_hang;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sb[$];
  wb_t mon_e;
  int  n_mp = 0;
  int  n_dp = 0;
  int  n_wb = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (ctrl_MULT) n_mp++;
      if (ctrl_DIV)  n_dp++;
      if (wb_valid && wb_ready) begin
        n_wb++;
        if (sb.size() == 0) begin
          check("wb_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_rd", wb_rd, mon_e.rd);
          check("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic im, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_is_mult = im; req_is_div = id;
    req_a = a; req_b = b; req_rd = rd;
    tick();
    req_valid = 1'b0; req_is_mult = 1'b0; req_is_div = 1'b0;
  endtask

  task automatic wait_wb(input int limit, output int n, output bit stall_low);
    n = 0;
    stall_low = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      n++;
      if (!stall) stall_low = 1'b1;
      if (wb_valid) break;
    end
    check("wb_arrives", wb_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int  n, mp0, dp0, wb0;
    bit  sl;
    reset = 1'b1; req_valid = 1'b0; req_is_mult = 1'b0; req_is_div = 1'b0;
    req_a = '0; req_b = '0; req_rd = '0; flush = 1'b0; wb_ready = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("rst_stall", stall, 0);
    check("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_operands", {data_operandA, data_operandB}, 0);
    check("rst_wb_payload", {wb_rd, wb_data}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Mult 7x6 -> rd 3, 42, unit latency 17.
    m_lat = 17; mp0 = n_mp;
    sb.push_back('{rd: 5'd3, data: 32'd42});
    check("t1_stall_idle", stall, 0);
    accept(1'b1, 1'b0, 32'd7, 32'd6, 5'd3);
    @(negedge clock);
    check("t1_mult_pulse", ctrl_MULT, 1);
    check("t1_stall_t1", stall, 1);
    tick();
    @(negedge clock);
    check("t1_mult_once", ctrl_MULT, 0);
    wait_wb(100, n, sl);
    check("t1_stall_span", sl, 0);
    check("t1_stall_hs", stall, 1);
    tick();
    @(negedge clock);
    check("t1_stall_after", stall, 0);
    check("t1_valid_after", wb_valid, 0);
    check("t1_mult_count", n_mp - mp0, 1);
    check("t1_operand_hold", data_operandA, 7);
    tick();

    // Div 100/0 -> exception writeback rd 30, code 5.
    m_lat = 5; mp0 = n_mp; dp0 = n_dp;
    sb.push_back('{rd: 5'd30, data: 32'd5});
    accept(1'b0, 1'b1, 32'd100, 32'd0, 5'd9);
    wait_wb(100, n, sl);
    tick();
    @(negedge clock);
    check("t2_div_count", n_dp - dp0, 1);
    check("t2_mult_count", n_mp - mp0, 0);
    tick();

    // Flush a mult in BUSY, accept div 9/3, stale RDY during ISSUE.
    m_lat = 30; wb0 = n_wb;
    sb.push_back('{rd: 5'd4, data: 32'd3});
    accept(1'b1, 1'b0, 32'd4, 32'd4, 5'd2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    check("t3_flush_stall", stall, 0);
    tick();
    m_lat = 5;
    accept(1'b0, 1'b1, 32'd9, 32'd3, 5'd4);
    inj_rdy = 1'b1; inj_data = 32'd999;
    @(negedge clock);
    check("t3_div_pulse", ctrl_DIV, 1);
    tick();
    inj_rdy = 1'b0;
    wait_wb(100, n, sl);
    tick();
    @(negedge clock);
    check("t3_single_wb", n_wb - wb0, 1);
    tick();

    // wb_ready low for 5 cycles in DONE.
    m_lat = 3; wb_ready = 1'b0;
    sb.push_back('{rd: 5'd7, data: 32'd25});
    accept(1'b1, 1'b0, 32'd5, 32'd5, 5'd7);
    wait_wb(100, n, sl);
    check("t4_payload_first", {wb_rd, wb_data}, {5'd7, 32'd25});
    for (int i = 1; i < 5; i++) begin
      tick();
      @(negedge clock);
      check("t4_hold_valid", {wb_valid, stall}, 2'b11);
      check("t4_hold_payload", {wb_rd, wb_data}, {5'd7, 32'd25});
    end
    tick();
    wb_ready = 1'b1;
    @(negedge clock);
    check("t4_valid_6th", {wb_valid, stall}, 2'b11);
    tick();
    @(negedge clock);
    check("t4_stall_after", {wb_valid, stall}, 2'b00);
    tick();

    // Both op bits set: mult wins, 2*3.
    m_lat = 4; mp0 = n_mp; dp0 = n_dp;
    sb.push_back('{rd: 5'd5, data: 32'd6});
    accept(1'b1, 1'b1, 32'd2, 32'd3, 5'd5);
    wait_wb(100, n, sl);
    tick();
    @(negedge clock);
    check("t5_mult_count", n_mp - mp0, 1);
    check("t5_div_count", n_dp - dp0, 0);
    tick();

    // Reset in BUSY: back to IDLE, late RDY from the unit is ignored.
    m_lat = 4; wb0 = n_wb;
    accept(1'b1, 1'b0, 32'd8, 32'd8, 5'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_idle", {stall, wb_valid}, 0);
    check("t6_rst_operand", data_operandA, 0);
    repeat (10) tick();
    @(negedge clock);
    check("t6_no_wb", n_wb - wb0, 0);
    check("t6_still_idle", stall, 0);
    tick();

`ifdef MULTDIV_TIMEOUT_EN
    // Unit never answers; watchdog produces the mult exception.
    m_hang = 1'b1; m_lat = 2;
    sb.push_back('{rd: 5'd30, data: 32'd4});
    accept(1'b1, 1'b0, 32'd3, 32'd3, 5'd6);
    wait_wb(50, n, sl);
    check("t7_timeout_cycle", n, 10);
    tick();
    @(negedge clock);
    check("t7_idle_after", {stall, wb_valid}, 0);
    m_hang = 1'b0;
    tick();
`endif

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Issue/writeback controller directly upstream of the multiply/divide unit in the processor's execute stage. Accepts a MULT or DIV instruction from execute, freezes the pipeline, registers and holds the operands, and issues a one-cycle start pulse to the unit. It then waits for result-ready and hands the result, or the `$rstatus` exception write, to writeback with a valid/ready handshake.

## Interface
- `DATA_W`, 32: operand/result width.
- `REG_W`, 5: destination register index width.
- `TIMEOUT_CYCLES`, 64: watchdog limit. Used only with `MULTDIV_TIMEOUT_EN`.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: execute presents a mult/div instruction.
- `req_is_mult`, `req_is_div` in 1: operation select. Mult wins if both are set.
- `req_a`, `req_b` in DATA_W: operands.
- `req_rd` in REG_W: destination register.
- `flush` in 1: kill any accepted or in-flight operation.
- `stall` out 1: freeze stages at and before execute.
- `ctrl_MULT`, `ctrl_DIV` out 1: one-cycle start pulses to the unit.
- `data_operandA`, `data_operandB` out DATA_W: registered operands, held stable until the next accept.
- `data_result` in DATA_W, `data_exception` in 1, `data_resultRDY` in 1: from the unit.
- `wb_valid` out 1, `wb_ready` in 1: writeback handshake.
- `wb_rd` out REG_W, `wb_data` out DATA_W: writeback payload.

## Operation
- States:
  - `IDLE`
  - `ISSUE`
  - `BUSY`
  - `DONE`
- Accept: in `IDLE`, when `req_valid & (req_is_mult|req_is_div) & !flush`:
  - register `a`, `b`, `rd` and the op bit.
  - go to `ISSUE`.
- `ISSUE`: assert exactly one of `ctrl_MULT`/`ctrl_DIV` for one cycle, then go to `BUSY`. `data_resultRDY` is ignored in `ISSUE`, so a stale RDY from a killed operation is never captured.
- `BUSY`: on `data_resultRDY`, capture the payload and go to `DONE`.
  - no exception: `wb_rd` = latched rd, `wb_data` = `data_result`.
  - exception: `wb_rd` = 30, `wb_data` = 4 (mult) or 5 (div).
- `DONE`: `wb_valid`=1 and payload held stable. When `wb_valid & wb_ready`, go to `IDLE`.
- `flush`: in `ISSUE`, `BUSY` or `DONE`, go to `IDLE` next cycle.
  - no `wb_valid` is produced for the killed operation.
  - a `ctrl_*` pulse already driven that cycle is still driven. The unit is restarted by the next issue.
- Flush priority: `flush` beats a same-cycle `data_resultRDY` and beats a same-cycle `wb_ready`. The result is dropped.
- `req_valid` while not `IDLE` is ignored; upstream is stalled.
- `rd`=0 is passed through unchanged; writeback discards it.

## Timing
- Reset values:
  - state `IDLE`.
  - `stall`, `ctrl_MULT`, `ctrl_DIV`, `wb_valid` = 0.
  - `data_operandA/B`, `wb_rd`, `wb_data` = 0.
- Accept in cycle T:
  - `ctrl_*` = 1 in T+1.
  - `BUSY` from T+2.
- `stall` is registered: 1 from T+1 through the handshake cycle, 0 the cycle after the handshake.
- RDY sampled in `BUSY` in cycle R: `wb_valid` = 1 from R+1.
- Earliest back-to-back accept is the cycle after the handshake.
- Reset mid-operation: return to `IDLE` at once. The unit may keep running; its RDY is ignored until the next issue.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - a watchdog counts `BUSY` cycles.
  - at `TIMEOUT_CYCLES` without RDY, go to `DONE` with the exception payload (`wb_rd`=30, code 4/5).
  - the counter clears on entry to `ISSUE`.
- Undefined: no counter. `BUSY` waits indefinitely.

## Structure
- Shared package `multdiv_pkg`:
  - state enum.
  - `RSTATUS_REG`=30, `EXC_MUL`=4, `EXC_DIV`=5.
- One sub-module, `multdiv_watchdog` (counter, clear, expire flag). It is instantiated only under `MULTDIV_TIMEOUT_EN`.
- The multdiv unit is not instantiated here; the bench or top level connects it.

## Test plan
- Mult 7×6, rd=3, unit model RDY after 17 cycles:
  - `ctrl_MULT` pulse at T+1.
  - `wb_valid` with rd=3, data=42.
  - `stall` high for exactly the span from T+1 to the handshake.
- Div 100/0, rd=9, model raises exception:
  - writeback of rd=30, data=5.
  - `ctrl_DIV` single pulse, `ctrl_MULT` never high.
- Mult accepted, `flush` in `BUSY`, new div 9/3 accepted two cycles later, old RDY arrives during `ISSUE`:
  - old RDY ignored.
  - single writeback data=3.
- `wb_ready` held low 5 cycles in `DONE`:
  - `wb_valid` and payload stable for 6 cycles.
  - `stall` stays 1 until the cycle after the handshake.
- `req_is_mult`=`req_is_div`=1 with 2,3: `ctrl_MULT` only, data=6.
- With `MULTDIV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, model never raises RDY on a mult:
  - writeback rd=30, data=4 on the 9th cycle after entering `BUSY`.
  - then `IDLE`.
